// File: rtl/regb_fifo_pkg.sv
// regb_fifo_pkg: shared defaults and width helpers for the regb FIFO family.
package regb_fifo_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_N = 5;
  function automatic int cw_of(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic int pw_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  localparam int DEF_PW = pw_of(DEF_N);
endpackage

// File: rtl/regb_fifo_ptr.sv
// regb_fifo_ptr: modulo-N wrap counter used for the FIFO read and write pointers.
module regb_fifo_ptr #(
  parameter int N = 5,
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          res,
  input  logic          inc,
  output logic [PW-1:0] ptr
);
  always_ff @(posedge clk)
    if (res) ptr <= '0;
    else if (inc) ptr <= (ptr == PW'(N - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/regb_fifo_param.sv
// regb_fifo_param: register-based FWFT FIFO with fill level and almost flags.
// Define REGB_FIFO_ERR_EN to add sticky overflow/underflow flags with err_clr.
module regb_fifo_param
  import regb_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N = DEF_N,
  parameter int AF_LVL = N - 1,
  parameter int AE_LVL = 1,
  localparam int CW = cw_of(N),
  localparam int PW = pw_of(N)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             shift_in,
  input  logic [WIDTH-1:0] in,
  output logic             full,
  input  logic             shift_out,
  output logic [WIDTH-1:0] out,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             almost_empty
`ifdef REGB_FIFO_ERR_EN
  ,
  output logic             overflow,
  output logic             underflow,
  input  logic             err_clr
`endif
);
  logic [WIDTH-1:0] mem [N];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic push, pop;
  assign push = shift_in && (!full || shift_out);
  assign pop = shift_out && !empty;
  assign full = count == CW'(N);
  assign empty = count == '0;
  assign almost_full = count >= CW'(AF_LVL);
  assign almost_empty = count <= CW'(AE_LVL);
  assign out = empty ? '0 : mem[rd_ptr];
  regb_fifo_ptr #(.N(N), .PW(PW)) u_rd (.clk(clk), .res(res), .inc(pop), .ptr(rd_ptr));
  regb_fifo_ptr #(.N(N), .PW(PW)) u_wr (.clk(clk), .res(res), .inc(push), .ptr(wr_ptr));
  always_ff @(posedge clk)
    if (push && !res) mem[wr_ptr] <= in;
  always_ff @(posedge clk)
    if (res) count <= '0;
    else if (push && !pop) count <= count + 1'b1;
    else if (pop && !push) count <= count - 1'b1;
`ifdef REGB_FIFO_ERR_EN
  // A set event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    overflow <= res ? 1'b0 : (shift_in && full && !shift_out) ? 1'b1 : err_clr ? 1'b0 : overflow;
    underflow <= res ? 1'b0 : (shift_out && empty) ? 1'b1 : err_clr ? 1'b0 : underflow;
  end
`endif
endmodule

// File: tb/tb_regb_fifo_param.sv
// tb_regb_fifo_param: directed self-checking bench for regb_fifo_param (N=5, WIDTH=4).
module tb_regb_fifo_param;
  logic clk = 0, res = 0, shift_in = 0, shift_out = 0;
  logic [3:0] din = 0, dout;
  logic full, empty, almost_full, almost_empty;
  logic [2:0] count;
  int tests = 0, fails = 0;
`ifdef REGB_FIFO_ERR_EN
  logic overflow, underflow, err_clr = 0;
`endif
  always #5 clk = ~clk;
  regb_fifo_param dut (
    .clk(clk), .res(res), .shift_in(shift_in), .in(din), .full(full),
    .shift_out(shift_out), .out(dout), .empty(empty), .count(count),
    .almost_full(almost_full), .almost_empty(almost_empty)
`ifdef REGB_FIFO_ERR_EN
    , .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
`endif
  );
  task automatic cyc(input logic si, input logic so, input logic [3:0] d);
    shift_in = si; shift_out = so; din = d;
    @(posedge clk); #1;
    shift_in = 0; shift_out = 0;
  endtask
  task automatic do_reset();
    res = 1; cyc(0, 0, 0); res = 0;
  endtask
  task automatic test_reset();
    do_reset();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b expected 0", full); end
    tests++; if (almost_empty !== 1'b1) begin fails++; $display("FAIL reset_ae: got %b expected 1", almost_empty); end
    tests++; if (almost_full !== 1'b0) begin fails++; $display("FAIL reset_af: got %b expected 0", almost_full); end
    tests++; if (dout !== 4'h0) begin fails++; $display("FAIL reset_out: got %h expected 0", dout); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
  endtask
  task automatic test_fill_drain();
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 0, 4'(k));
      tests++; if (count !== 3'(k)) begin fails++; $display("FAIL fill_count%0d: got %0d expected %0d", k, count, k); end
      tests++; if (almost_full !== (k >= 4)) begin fails++; $display("FAIL fill_af%0d: got %b expected %b", k, almost_full, k >= 4); end
      tests++; if (almost_empty !== (k <= 1)) begin fails++; $display("FAIL fill_ae%0d: got %b expected %b", k, almost_empty, k <= 1); end
      tests++; if (full !== (k == 5)) begin fails++; $display("FAIL fill_full%0d: got %b expected %b", k, full, k == 5); end
      tests++; if (dout !== 4'h1) begin fails++; $display("FAIL fill_head%0d: got %h expected 1", k, dout); end
    end
    cyc(1, 0, 4'hF);
    tests++; if (count !== 3'd5) begin fails++; $display("FAIL overpush_count: got %0d expected 5", count); end
    tests++; if (dout !== 4'h1) begin fails++; $display("FAIL overpush_head: got %h expected 1", dout); end
`ifdef REGB_FIFO_ERR_EN
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_set: got %b expected 1", overflow); end
`endif
    for (int k = 1; k <= 5; k++) begin
      tests++; if (dout !== 4'(k)) begin fails++; $display("FAIL drain%0d: got %h expected %h", k, dout, 4'(k)); end
      cyc(0, 1, 0);
    end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL drain_empty: got %b expected 1", empty); end
    tests++; if (dout !== 4'h0) begin fails++; $display("FAIL drain_out: got %h expected 0", dout); end
    cyc(0, 1, 0);
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL underpop_count: got %0d expected 0", count); end
  endtask
  task automatic test_wrap();
    for (int r = 0; r < 4; r++) begin
      for (int j = 0; j < 3; j++) cyc(1, 0, 4'(r * 3 + j));
      tests++; if (count !== 3'd3) begin fails++; $display("FAIL wrap_count%0d: got %0d expected 3", r, count); end
      for (int j = 0; j < 3; j++) begin
        tests++; if (dout !== 4'(r * 3 + j)) begin fails++; $display("FAIL wrap_pop%0d: got %h expected %h", r * 3 + j, dout, 4'(r * 3 + j)); end
        cyc(0, 1, 0);
      end
      tests++; if (empty !== 1'b1) begin fails++; $display("FAIL wrap_empty%0d: got %b expected 1", r, empty); end
    end
  endtask
  task automatic test_full_both();
    logic [3:0] exp_seq [5];
    exp_seq = '{4'h2, 4'h3, 4'h4, 4'h5, 4'hA};
    for (int k = 1; k <= 5; k++) cyc(1, 0, 4'(k));
    cyc(1, 1, 4'hA);
    tests++; if (count !== 3'd5) begin fails++; $display("FAIL fullboth_count: got %0d expected 5", count); end
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL fullboth_full: got %b expected 1", full); end
    for (int k = 0; k < 5; k++) begin
      tests++; if (dout !== exp_seq[k]) begin fails++; $display("FAIL fullboth_seq%0d: got %h expected %h", k, dout, exp_seq[k]); end
      cyc(0, 1, 0);
    end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL fullboth_empty: got %b expected 1", empty); end
  endtask
  task automatic test_empty_both();
    do_reset();
    cyc(1, 1, 4'h7);
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL emptyboth_count: got %0d expected 1", count); end
    tests++; if (dout !== 4'h7) begin fails++; $display("FAIL emptyboth_out: got %h expected 7", dout); end
    tests++; if (empty !== 1'b0) begin fails++; $display("FAIL emptyboth_empty: got %b expected 0", empty); end
`ifdef REGB_FIFO_ERR_EN
    tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL underflow_set: got %b expected 1", underflow); end
`endif
    cyc(0, 1, 0);
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL emptyboth_drain: got %b expected 1", empty); end
  endtask
  task automatic test_reset_mid();
    for (int k = 1; k <= 3; k++) cyc(1, 0, 4'(k));
    shift_in = 1; din = 4'h9; res = 1;
    @(posedge clk); #1;
    res = 0; shift_in = 0;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL midrst_count: got %0d expected 0", count); end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL midrst_empty: got %b expected 1", empty); end
    tests++; if (dout !== 4'h0) begin fails++; $display("FAIL midrst_out: got %h expected 0", dout); end
    cyc(1, 0, 4'h6);
    tests++; if (dout !== 4'h6) begin fails++; $display("FAIL midrst_push: got %h expected 6", dout); end
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL midrst_push_count: got %0d expected 1", count); end
    cyc(0, 1, 0);
  endtask
`ifdef REGB_FIFO_ERR_EN
  task automatic test_err();
    do_reset();
    tests++; if ({overflow, underflow} !== 2'b00) begin fails++; $display("FAIL err_reset: got %b expected 00", {overflow, underflow}); end
    for (int k = 1; k <= 5; k++) cyc(1, 0, 4'(k));
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL err_nofalse: got %b expected 0", overflow); end
    cyc(1, 0, 4'hF);
    cyc(0, 0, 0);
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL err_hold: got %b expected 1", overflow); end
    err_clr = 1; cyc(0, 0, 0); err_clr = 0;
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL err_clr: got %b expected 0", overflow); end
    err_clr = 1; cyc(1, 0, 4'hF); err_clr = 0;
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL err_set_wins: got %b expected 1", overflow); end
    do_reset();
  endtask
`endif
  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_both();
    test_empty_both();
    test_reset_mid();
`ifdef REGB_FIFO_ERR_EN
    test_err();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
